timekeeper_register: RTL and testbench
======================================

# timekeeper_register

Parametrised time-of-day register for the 7-segment clock core: counts seconds/minutes/hours from a 1 Hz strobe with configurable rollover limits. It adds bidirectional button setting, parallel load, alarm match and day-rollover strobes, and 12 h display mapping. It sits between the 1 Hz prescaler/button debouncers and the BCD/display path.

## Interface
- SEC_MAX, 59, last seconds value before wrap to 0
- MIN_MAX, 59, last minutes value before wrap to 0
- HOUR_MAX, 23, last hours value before wrap to 0
- SEC_W, 6, seconds width (must hold SEC_MAX)
- MIN_W, 6, minutes width
- HOUR_W, 5, hours width

Ports:
- i_clk  in  1  system clock; all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_1hz_stb  in  1  one-cycle 1 Hz tick
- i_set_stb  in  1  one-cycle set-repeat tick
- i_set_hours, i_set_minutes  in  1 each  set-mode buttons (levels)
- i_set_down  in  1  set direction: 0 increment, 1 decrement
- i_load  in  1  one-cycle parallel load request
- i_load_hours / i_load_minutes / i_load_seconds  in  HOUR_W/MIN_W/SEC_W  load values
- i_alarm_en  in  1  alarm enable
- i_alarm_hours / i_alarm_minutes  in  HOUR_W/MIN_W  alarm time
- i_mode_12h  in  1  display mode select
- o_hours / o_minutes / o_seconds  out  HOUR_W/MIN_W/SEC_W  registered 24 h time
- o_disp_hours  out  HOUR_W  display hours (combinational from o_hours)
- o_pm  out  1  o_hours >= 12 (combinational)
- o_alarm_stb  out  1  registered one-cycle alarm pulse
- o_day_stb  out  1  registered one-cycle midnight pulse

## Operation
- Reset (async, i_reset_n low): all registered outputs 0; o_disp_hours = 12 if i_mode_12h else 0.
- Per-cycle priority, highest first: reset > i_load > both set buttons > single set button > normal counting.
- Load: each field takes its load value; a field above its MAX loads 0. Strobes do not fire on a load.
- Both set buttons held: seconds forced to 0 and held; minutes/hours frozen.
- Set-hours only (set-minutes only): on i_set_stb, that field steps ±1 per i_set_down, wrapping MAX->0 up and 0->MAX down; no carry into other fields. Seconds keep counting on i_1hz_stb, but seconds wrap produces no minute carry while any set button is held.
- Normal counting on i_1hz_stb: seconds +1; at SEC_MAX wrap to 0 and carry; minutes likewise into hours; hours at HOUR_MAX wrap to 0.
- o_day_stb: asserted for the cycle in which the counting transition HOUR_MAX:MIN_MAX:SEC_MAX -> 0:0:0 becomes visible. Set-mode or load wraps never assert it.
- o_alarm_stb: asserted for the cycle in which a counting tick makes the registers equal i_alarm_hours:i_alarm_minutes:00. Requires i_alarm_en high and no set button held at the tick. Load/set reaching the alarm time does not fire it.
- Safety: any field found above its MAX (unreachable normally) is cleared to 0 next cycle, below load priority.
- 12 h mapping (i_mode_12h=1): o_hours 0 -> 12, 1..12 -> same, 13..23 -> 1..11. If i_mode_12h=0, o_disp_hours = o_hours. o_pm is independent of mode.

## Timing
- One-cycle latency: a strobe/load sampled at edge N shows on outputs after edge N.
- o_alarm_stb/o_day_stb are high exactly one cycle, coincident with the new time value; 0 otherwise.
- Simultaneous i_1hz_stb and i_set_stb with one set button: both apply in the same cycle (seconds tick, set field steps).
- i_load with any strobe: load wins, strobes ignored that cycle.
- Reset asserted mid-count clears immediately (asynchronous). Counting resumes on the first i_1hz_stb after release.

## Test plan
- Reset, then 60 i_1hz_stb -> 00:01:00; load 23:59:58 and 2 ticks -> 00:00:00, o_day_stb high one cycle on second tick only.
- Hold i_set_minutes, i_set_down=1, at 10:00:30 pulse i_set_stb twice -> 10:58:30, hours unchanged; seconds wrap at 59 gives no minute carry.
- Hold both set buttons at 12:34:45 -> seconds 0 next cycle, held at 0 across 5 ticks; release -> counting resumes 12:34:01 after one tick.
- Alarm 07:30, enabled; load 07:29:59, tick -> o_alarm_stb one cycle with 07:30:00. Repeat with i_alarm_en=0 -> no pulse. Load 07:30:00 directly -> no pulse.
- i_mode_12h=1: o_hours 0, 12, 13, 23 -> o_disp_hours 12, 12, 1, 11; o_pm 0, 1, 1, 1. Load hours=30 -> o_hours 0.
- Parameters SEC_MAX=9, MIN_MAX=9, HOUR_MAX=3: load 3:9:9, tick -> 0:0:0 with o_day_stb; assert i_reset_n low mid-cycle -> outputs 0 before next edge.

Source files
------------

// File: rtl/timekeeper_register.sv
// Time-of-day register: seconds/minutes/hours counter with button setting,
// parallel load, alarm and midnight strobes, and 12 h display mapping.
module timekeeper_register #(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23,
    parameter int SEC_W    = 6,
    parameter int MIN_W    = 6,
    parameter int HOUR_W   = 5
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_1hz_stb,
    input  logic              i_set_stb,
    input  logic              i_set_hours,
    input  logic              i_set_minutes,
    input  logic              i_set_down,
    input  logic              i_load,
    input  logic [HOUR_W-1:0] i_load_hours,
    input  logic [MIN_W-1:0]  i_load_minutes,
    input  logic [SEC_W-1:0]  i_load_seconds,
    input  logic              i_alarm_en,
    input  logic [HOUR_W-1:0] i_alarm_hours,
    input  logic [MIN_W-1:0]  i_alarm_minutes,
    input  logic              i_mode_12h,
    output logic [HOUR_W-1:0] o_hours,
    output logic [MIN_W-1:0]  o_minutes,
    output logic [SEC_W-1:0]  o_seconds,
    output logic [HOUR_W-1:0] o_disp_hours,
    output logic              o_pm,
    output logic              o_alarm_stb,
    output logic              o_day_stb
);

    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);
    localparam logic [HOUR_W-1:0] HOUR_NOON = HOUR_W'(12);

    // Operation chosen for this cycle, in priority order.
    typedef enum logic [1:0] {
        OP_COUNT,
        OP_SET_ONE,
        OP_SET_BOTH,
        OP_LOAD
    } op_e;

    op_e               w_op;

    logic [SEC_W-1:0]  r_seconds;
    logic [MIN_W-1:0]  r_minutes;
    logic [HOUR_W-1:0] r_hours;
    logic              r_alarm_stb;
    logic              r_day_stb;

    logic [SEC_W-1:0]  w_seconds_nxt;
    logic [MIN_W-1:0]  w_minutes_nxt;
    logic [HOUR_W-1:0] w_hours_nxt;
    logic              w_alarm_nxt;
    logic              w_day_nxt;

    logic              w_sec_at_max;
    logic              w_min_at_max;
    logic              w_hour_at_max;
    logic [SEC_W-1:0]  w_sec_inc;
    logic [MIN_W-1:0]  w_min_inc;
    logic [MIN_W-1:0]  w_min_dec;
    logic [HOUR_W-1:0] w_hour_inc;
    logic [HOUR_W-1:0] w_hour_dec;
    logic [HOUR_W-1:0] w_disp_hours;

    always_comb begin
        w_op = OP_COUNT;
        if (i_load) begin
            w_op = OP_LOAD;
        end else if (i_set_hours && i_set_minutes) begin
            w_op = OP_SET_BOTH;
        end else if (i_set_hours || i_set_minutes) begin
            w_op = OP_SET_ONE;
        end
    end

    assign w_sec_at_max  = (r_seconds == SEC_LAST);
    assign w_min_at_max  = (r_minutes == MIN_LAST);
    assign w_hour_at_max = (r_hours == HOUR_LAST);

    assign w_sec_inc  = w_sec_at_max  ? '0 : r_seconds + 1'b1;
    assign w_min_inc  = w_min_at_max  ? '0 : r_minutes + 1'b1;
    assign w_hour_inc = w_hour_at_max ? '0 : r_hours + 1'b1;
    assign w_min_dec  = (r_minutes == '0) ? MIN_LAST  : r_minutes - 1'b1;
    assign w_hour_dec = (r_hours == '0)   ? HOUR_LAST : r_hours - 1'b1;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_seconds_nxt = r_seconds;
        w_minutes_nxt = r_minutes;
        w_hours_nxt   = r_hours;
        w_day_nxt     = 1'b0;
        w_alarm_nxt   = 1'b0;

        case (w_op)
            OP_LOAD: begin
                w_seconds_nxt = (i_load_seconds > SEC_LAST)  ? '0 : i_load_seconds;
                w_minutes_nxt = (i_load_minutes > MIN_LAST)  ? '0 : i_load_minutes;
                w_hours_nxt   = (i_load_hours   > HOUR_LAST) ? '0 : i_load_hours;
            end
            OP_SET_BOTH: begin
                w_seconds_nxt = '0;
            end
            OP_SET_ONE: begin
                // Seconds run freely but never carry while a set button is held.
                if (i_1hz_stb) begin
                    w_seconds_nxt = w_sec_inc;
                end
                if (i_set_stb) begin
                    if (i_set_hours) begin
                        w_hours_nxt = i_set_down ? w_hour_dec : w_hour_inc;
                    end else begin
                        w_minutes_nxt = i_set_down ? w_min_dec : w_min_inc;
                    end
                end
            end
            default: begin
                if (i_1hz_stb) begin
                    w_seconds_nxt = w_sec_inc;
                    if (w_sec_at_max) begin
                        w_minutes_nxt = w_min_inc;
                        if (w_min_at_max) begin
                            w_hours_nxt = w_hour_inc;
                            w_day_nxt   = w_hour_at_max;
                        end
                    end
                end
            end
        endcase

        // Recover from any out-of-range field; a load overrides this.
        if (w_op != OP_LOAD) begin
            if (r_seconds > SEC_LAST) begin
                w_seconds_nxt = '0;
            end
            if (r_minutes > MIN_LAST) begin
                w_minutes_nxt = '0;
            end
            if (r_hours > HOUR_LAST) begin
                w_hours_nxt = '0;
            end
        end

        w_alarm_nxt = (w_op == OP_COUNT) && i_1hz_stb && i_alarm_en && w_sec_at_max
                      && (w_minutes_nxt == i_alarm_minutes)
                      && (w_hours_nxt == i_alarm_hours);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_seconds   <= '0;
            r_minutes   <= '0;
            r_hours     <= '0;
            r_alarm_stb <= 1'b0;
            r_day_stb   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_seconds   <= w_seconds_nxt;
            r_minutes   <= w_minutes_nxt;
            r_hours     <= w_hours_nxt;
            r_alarm_stb <= w_alarm_nxt;
            r_day_stb   <= w_day_nxt;
        end
    end

    always_comb begin
        w_disp_hours = r_hours;
        if (i_mode_12h) begin
            if (r_hours == '0) begin
                w_disp_hours = HOUR_NOON;
            end else if (r_hours > HOUR_NOON) begin
                w_disp_hours = r_hours - HOUR_NOON;
            end
        end
    end

    assign o_hours      = r_hours;
    assign o_minutes    = r_minutes;
    assign o_seconds    = r_seconds;
    assign o_disp_hours = w_disp_hours;
    assign o_pm         = (r_hours >= HOUR_NOON);
    assign o_alarm_stb  = r_alarm_stb;
    assign o_day_stb    = r_day_stb;

endmodule

// File: tb/tb_timekeeper_register.sv
// Bench for timekeeper_register: a default 24 h instance and a small 4:10:10
// instance share stimulus and are compared every cycle against an arithmetic model.
module tb_timekeeper_register;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hz, set_stb, set_h, set_m, set_down, load;
    logic [HOUR_W-1:0] ld_h;
    logic [MIN_W-1:0]  ld_m;
    logic [SEC_W-1:0]  ld_s;
    logic              al_en;
    logic [HOUR_W-1:0] al_h;
    logic [MIN_W-1:0]  al_m;
    logic              mode12;

    logic [HOUR_W-1:0] o_h    [2];
    logic [MIN_W-1:0]  o_m    [2];
    logic [SEC_W-1:0]  o_s    [2];
    logic [HOUR_W-1:0] o_disp [2];
    logic              o_pm   [2];
    logic              o_al   [2];
    logic              o_day  [2];

    int checks = 0;
    int errors = 0;

    // Model state: time per instance and the strobes expected this cycle.
    int mh [2];
    int mm [2];
    int ms [2];
    int mday [2];
    int malarm [2];

    always #5 clk = ~clk;

    timekeeper_register dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_1hz_stb(hz), .i_set_stb(set_stb),
        .i_set_hours(set_h), .i_set_minutes(set_m), .i_set_down(set_down),
        .i_load(load), .i_load_hours(ld_h), .i_load_minutes(ld_m), .i_load_seconds(ld_s),
        .i_alarm_en(al_en), .i_alarm_hours(al_h), .i_alarm_minutes(al_m),
        .i_mode_12h(mode12),
        .o_hours(o_h[0]), .o_minutes(o_m[0]), .o_seconds(o_s[0]),
        .o_disp_hours(o_disp[0]), .o_pm(o_pm[0]),
        .o_alarm_stb(o_al[0]), .o_day_stb(o_day[0])
    );

    timekeeper_register #(
        .SEC_MAX(9), .MIN_MAX(9), .HOUR_MAX(3)
    ) dut_s (
        .i_clk(clk), .i_reset_n(rst_n), .i_1hz_stb(hz), .i_set_stb(set_stb),
        .i_set_hours(set_h), .i_set_minutes(set_m), .i_set_down(set_down),
        .i_load(load), .i_load_hours(ld_h), .i_load_minutes(ld_m), .i_load_seconds(ld_s),
        .i_alarm_en(al_en), .i_alarm_hours(al_h), .i_alarm_minutes(al_m),
        .i_mode_12h(mode12),
        .o_hours(o_h[1]), .o_minutes(o_m[1]), .o_seconds(o_s[1]),
        .o_disp_hours(o_disp[1]), .o_pm(o_pm[1]),
        .o_alarm_stb(o_al[1]), .o_day_stb(o_day[1])
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Time is treated as one count of seconds since midnight modulo the day length.
    task automatic model_step(input int k);
        int smax, mmax, hmax, total, day_len;
        smax = (k == 0) ? 59 : 9;
        mmax = (k == 0) ? 59 : 9;
        hmax = (k == 0) ? 23 : 3;
        mday[k]   = 0;
        malarm[k] = 0;
        if (load) begin
            mh[k] = (int'(ld_h) > hmax) ? 0 : int'(ld_h);
            mm[k] = (int'(ld_m) > mmax) ? 0 : int'(ld_m);
            ms[k] = (int'(ld_s) > smax) ? 0 : int'(ld_s);
        end else if (set_h && set_m) begin
            ms[k] = 0;
        end else if (set_h || set_m) begin
            if (hz) ms[k] = (ms[k] + 1) % (smax + 1);
            if (set_stb) begin
                if (set_h) mh[k] = (mh[k] + (set_down ? hmax : 1)) % (hmax + 1);
                else       mm[k] = (mm[k] + (set_down ? mmax : 1)) % (mmax + 1);
            end
        end else if (hz) begin
            day_len = (hmax + 1) * (mmax + 1) * (smax + 1);
            total   = ((mh[k] * (mmax + 1) + mm[k]) * (smax + 1) + ms[k] + 1) % day_len;
            ms[k]   = total % (smax + 1);
            mm[k]   = (total / (smax + 1)) % (mmax + 1);
            mh[k]   = total / ((smax + 1) * (mmax + 1));
            mday[k] = (total == 0) ? 1 : 0;
            malarm[k] = (al_en && ms[k] == 0 && mm[k] == int'(al_m) && mh[k] == int'(al_h)) ? 1 : 0;
        end
    endtask

    function automatic int disp_of(input int h, input logic m12);
        if (!m12)   return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mh[k] = 0; mm[k] = 0; ms[k] = 0; mday[k] = 0; malarm[k] = 0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("hours[%0d]", k),   int'(o_h[k]),    mh[k]);
            check($sformatf("minutes[%0d]", k), int'(o_m[k]),    mm[k]);
            check($sformatf("seconds[%0d]", k), int'(o_s[k]),    ms[k]);
            check($sformatf("disp[%0d]", k),    int'(o_disp[k]), disp_of(mh[k], mode12));
            check($sformatf("pm[%0d]", k),      int'(o_pm[k]),   (mh[k] >= 12) ? 1 : 0);
            check($sformatf("alarm[%0d]", k),   int'(o_al[k]),   malarm[k]);
            check($sformatf("day[%0d]", k),     int'(o_day[k]),  mday[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hz = 1'b1;
        step();
        hz = 1'b0;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        ld_h = HOUR_W'(h);
        ld_m = MIN_W'(m);
        ld_s = SEC_W'(s);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic set_pulse();
        set_stb = 1'b1;
        step();
        set_stb = 1'b0;
    endtask

    task automatic check_time(input string name, input int k, input int h, input int m, input int s);
        check({name, "_h"}, int'(o_h[k]), h);
        check({name, "_m"}, int'(o_m[k]), m);
        check({name, "_s"}, int'(o_s[k]), s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hours_tab [6] = '{0, 12, 13, 23, 1, 11};
        int disp_tab  [6] = '{12, 12, 1, 11, 1, 11};
        int pm_tab    [6] = '{0, 1, 1, 1, 0, 0};

        rst_n = 1'b0;
        hz = 0; set_stb = 0; set_h = 0; set_m = 0; set_down = 0; load = 0;
        ld_h = '0; ld_m = '0; ld_s = '0;
        al_en = 0; al_h = '0; al_m = '0; mode12 = 0;

        repeat (3) step();
        check_time("reset", 0, 0, 0, 0);
        check("reset_disp24", int'(o_disp[0]), 0);
        mode12 = 1'b1;
        #1;
        check("reset_disp12", int'(o_disp[0]), 12);
        check("reset_pm", int'(o_pm[0]), 0);
        mode12 = 1'b0;
        rst_n = 1'b1;
        step();

        repeat (60) tick();
        check_time("sixty_ticks", 0, 0, 1, 0);

        do_load(23, 59, 58);
        tick();
        check_time("pre_midnight", 0, 23, 59, 59);
        check("pre_midnight_day", int'(o_day[0]), 0);
        tick();
        check_time("midnight", 0, 0, 0, 0);
        check("midnight_day", int'(o_day[0]), 1);
        step();
        check("midnight_day_drop", int'(o_day[0]), 0);

        do_load(10, 0, 30);
        set_m = 1'b1;
        set_down = 1'b1;
        set_pulse();
        step();
        set_pulse();
        check_time("set_min_down", 0, 10, 58, 30);
        do_load(10, 58, 59);
        tick();
        check_time("set_no_carry", 0, 10, 58, 0);
        hz = 1'b1;
        set_stb = 1'b1;
        step();
        hz = 1'b0;
        set_stb = 1'b0;
        check_time("set_and_tick", 0, 10, 57, 1);
        set_m = 1'b0;
        set_down = 1'b0;

        set_h = 1'b1;
        do_load(23, 0, 0);
        set_pulse();
        check("set_hour_wrap", int'(o_h[0]), 0);
        check("set_hour_wrap_day", int'(o_day[0]), 0);
        set_h = 1'b0;

        hz = 1'b1;
        set_stb = 1'b1;
        do_load(1, 2, 3);
        hz = 1'b0;
        set_stb = 1'b0;
        check_time("load_beats_strobes", 0, 1, 2, 3);

        do_load(12, 34, 45);
        set_h = 1'b1;
        set_m = 1'b1;
        step();
        check_time("both_set", 0, 12, 34, 0);
        repeat (5) tick();
        check_time("both_set_hold", 0, 12, 34, 0);
        set_h = 1'b0;
        set_m = 1'b0;
        tick();
        check_time("both_release", 0, 12, 34, 1);

        al_h = 5'd7;
        al_m = 6'd30;
        al_en = 1'b1;
        do_load(7, 29, 59);
        tick();
        check("alarm_fire", int'(o_al[0]), 1);
        check_time("alarm_time", 0, 7, 30, 0);
        step();
        check("alarm_drop", int'(o_al[0]), 0);
        al_en = 1'b0;
        do_load(7, 29, 59);
        tick();
        check("alarm_disabled", int'(o_al[0]), 0);
        al_en = 1'b1;
        do_load(7, 30, 0);
        check("alarm_on_load", int'(o_al[0]), 0);
        set_h = 1'b1;
        do_load(7, 29, 59);
        tick();
        check("alarm_set_held", int'(o_al[0]), 0);
        set_h = 1'b0;
        al_en = 1'b0;

        mode12 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_load(hours_tab[i], 0, 0);
            check($sformatf("disp12_%0d", hours_tab[i]), int'(o_disp[0]), disp_tab[i]);
            check($sformatf("pm_%0d", hours_tab[i]), int'(o_pm[0]), pm_tab[i]);
        end
        do_load(30, 0, 0);
        check("load_over_max", int'(o_h[0]), 0);
        mode12 = 1'b0;
        do_load(13, 0, 0);
        check("disp24_13", int'(o_disp[0]), 13);

        do_load(3, 9, 9);
        check_time("small_load", 1, 3, 9, 9);
        tick();
        check_time("small_wrap", 1, 0, 0, 0);
        check("small_day", int'(o_day[1]), 1);
        check("big_no_day", int'(o_day[0]), 0);

        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_time("async_reset_big", 0, 0, 0, 0);
        check_time("async_reset_small", 1, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        check_time("post_reset_idle", 0, 0, 0, 0);
        tick();
        check_time("post_reset_tick", 1, 0, 0, 1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
